di_debounce_array: RTL and testbench
====================================

DI_DEBOUNCE_ARRAY -- requirements
Module: di_debounce_array

Interface
- REQ-001 The block SHALL have the parameter `CH`, default 8: number of independent DI channels (1..32).
- REQ-002 The block SHALL have the parameter `CW`, default 8: debounce counter and threshold width in bits (2..16).
- REQ-003 The block SHALL have the parameter `INIT`, default {CH{1'b0}}: per-channel reset level of the synchroniser and of `di_o`.
- REQ-004 The block SHALL have the port `clk`  input  1: system clock, 10 MHz nominal; single clock domain.
- REQ-005 The block SHALL have the port `rst_n`  input  1: reset, asynchronous and active-low.
- REQ-006 The block SHALL have the port `in_i`  input  CH: raw, asynchronous, bouncing DI inputs.
- REQ-007 The block SHALL have the port `shake_th`  input  CW: stability threshold in clk cycles, shared by all channels, sampled every cycle.
- REQ-008 The block SHALL have the port `di_o`  output  CH: debounced levels, registered.
- REQ-009 The block SHALL have the port `rise_p`  output  CH: one-cycle pulse, coincident with a 0->1 update of `di_o`.
- REQ-010 The block SHALL have the port `fall_p`  output  CH: one-cycle pulse, coincident with a 1->0 update of `di_o`.
- REQ-011 The block SHALL have the port `edge_flag`  output  CH: sticky per-channel change flags.
- REQ-012 The block SHALL have the port `irq`  output  1: OR of `edge_flag`, registered.
- REQ-013 The block SHALL have the port `flag_clr`  input  CH: write-one-to-clear for `edge_flag`, one-cycle strobe.

Function
- REQ-014 Each channel SHALL pass `in_i` through a 2-flop synchroniser; the output of this synchroniser is called s.
- REQ-015 Each channel SHALL hold a CW-bit counter cnt and the stable state `di_o`.
- REQ-016 When s == `di_o`, the channel SHALL set cnt to 0 on that clock.
- REQ-017 When s != `di_o` and cnt + 1 < th_eff, the channel SHALL increment cnt by 1.
- REQ-018 When s != `di_o` and cnt + 1 >= th_eff, the channel SHALL, on the same clock, set `di_o` to s, set cnt to 0, and assert `rise_p` or `fall_p` (per REQ-009/REQ-010) for exactly that one cycle.
- REQ-019 th_eff SHALL be `shake_th`, except that `shake_th` = 0 SHALL be treated as th_eff = 1.
- REQ-020 cnt SHALL never wrap, because it is cleared at th_eff; the comparison SHALL be carried out at CW+1 bits.
- REQ-021 Latency from a clean level change on `in_i` (set up before edge k) to `di_o` updating SHALL be exactly th_eff + 2 clock edges.
- REQ-022 A disturbance shorter than th_eff synchronised cycles SHALL NOT change `di_o` or produce any pulse.
- REQ-023 Any return of s to `di_o` SHALL restart the count from 0.
- REQ-024 A change of `shake_th` mid-count SHALL apply from the next comparison; if cnt + 1 already meets or exceeds the new th_eff, the channel SHALL update on that clock.
- REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
- REQ-026 `rise_p` and `fall_p` of the same channel SHALL never be asserted together.

Reset
- REQ-027 On `rst_n` low, the block SHALL immediately (asynchronously) set synchroniser flops and `di_o` to `INIT`, cnt to 0, `rise_p`, `fall_p` and `edge_flag` to 0, and `irq` to 0.
- REQ-028 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be generated on reset entry or exit.
- REQ-029 After `rst_n` deasserts, an `in_i` level differing from `INIT` SHALL update `di_o` after th_eff + 2 cycles, with a normal edge pulse.

Configuration
- REQ-030 The macro `DI_EDGE_IRQ_EN` SHALL select whether the sticky-flag/interrupt logic is compiled in; the port list SHALL be identical in both builds.
- REQ-031 With `DI_EDGE_IRQ_EN` defined, `edge_flag[i]` SHALL set on the clock after `rise_p[i]` or `fall_p[i]`.
- REQ-032 With `DI_EDGE_IRQ_EN` defined, `edge_flag[i]` SHALL clear on the clock after `flag_clr[i]`.
- REQ-033 With `DI_EDGE_IRQ_EN` defined, a simultaneous set and clear on the same channel SHALL leave `edge_flag[i]` set (set wins).
- REQ-034 With `DI_EDGE_IRQ_EN` defined, `irq` SHALL equal the OR of `edge_flag`, registered, lagging `edge_flag` by 1 cycle.
- REQ-035 With `DI_EDGE_IRQ_EN` not defined, `edge_flag` SHALL be constant 0, `irq` SHALL be constant 0, and `flag_clr` SHALL be ignored, with no flag registers synthesised.

Verification
- REQ-036 The bench SHALL drive CH=8, `shake_th`=4 and a clean 0->1 on `in_i[0]` before edge k, and check that `di_o[0]`=1 at edge k+6 and that `rise_p[0]` is high for exactly one cycle, with all other channels static.
- REQ-037 The bench SHALL drive `shake_th`=4 and a 3-cycle high glitch on `in_i[3]`, and check that `di_o[3]` stays 0 and that no pulse, flag or `irq` occurs.
- REQ-038 The bench SHALL drive `shake_th`=0 with a 1-cycle pulse on `in_i[1]`, and check that `di_o[1]` follows with 3-cycle latency and that both `rise_p[1]` and `fall_p[1]` appear.
- REQ-039 The bench SHALL drive `in_i`=8'hFF with `INIT`=0 and `shake_th`=100, assert `rst_n` low at count 50 and release it, and check that `di_o` is 0 during reset and that `di_o`=8'hFF exactly 102 cycles after release.
- REQ-040 In the `DI_EDGE_IRQ_EN` build, the bench SHALL produce a fall on channel 2 and then pulse `flag_clr[2]` in the same cycle as a new rise, and check that `edge_flag[2]` stays 1 and `irq` stays 1.
- REQ-041 In the `DI_EDGE_IRQ_EN` build, the bench SHALL pulse `flag_clr` alone afterwards, and check that `edge_flag[2]` becomes 0 and `irq` becomes 0 one cycle later.
- REQ-042 In the build without `DI_EDGE_IRQ_EN`, the bench SHALL run the same stimulus as REQ-040/REQ-041 and check that `edge_flag` and `irq` remain 0 throughout.

Source files
------------

// File: rtl/di_debounce_array.sv
// Multi-channel digital-input debouncer: 2-flop synchroniser, per-channel stability counter, edge pulses.
// Define DI_EDGE_IRQ_EN to build in the sticky edge flags and the interrupt output.
module di_debounce_array #(
    parameter int            CH   = 8,
    parameter int            CW   = 8,
    parameter logic [CH-1:0] INIT = {CH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] in_i,
    input  logic [CW-1:0] shake_th,
    output logic [CH-1:0] di_o,
    output logic [CH-1:0] rise_p,
    output logic [CH-1:0] fall_p,
    output logic [CH-1:0] edge_flag,
    output logic          irq,
    input  logic [CH-1:0] flag_clr
);

    localparam logic [CW:0] CNT_ONE = {{CW{1'b0}}, 1'b1};

    logic [CH-1:0]         sync1_q;
    logic [CH-1:0]         sync2_q;
    logic [CH-1:0]         di_q;
    logic [CH-1:0]         di_d;
    logic [CH-1:0]         rise_q;
    logic [CH-1:0]         rise_d;
    logic [CH-1:0]         fall_q;
    logic [CH-1:0]         fall_d;
    logic [CH-1:0][CW-1:0] cnt_q;
    logic [CH-1:0][CW-1:0] cnt_d;
    logic [CW:0]           th_eff;
    logic [CW:0]           cnt_inc;

    // A threshold of zero behaves like one so a channel can never stall.
    always_comb begin
        th_eff = (shake_th == '0) ? CNT_ONE : {1'b0, shake_th};
    end

    // The increment is formed one bit wider so reaching the threshold never wraps.
    always_comb begin
        di_d    = di_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = '0;
        cnt_inc = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_inc = {1'b0, cnt_q[i]} + CNT_ONE;
            if (sync2_q[i] != di_q[i]) begin
                if (cnt_inc >= th_eff) begin
                    di_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_inc[CW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
            di_q    <= INIT;
            rise_q  <= '0;
            fall_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
            di_q    <= di_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign di_o   = di_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;

`ifdef DI_EDGE_IRQ_EN
    logic [CH-1:0] flag_q;
    logic [CH-1:0] flag_d;
    logic          irq_q;
    logic          irq_d;

    // A new edge outranks a clear strobe arriving in the same cycle.
    always_comb begin
        flag_d = (flag_q & ~flag_clr) | rise_q | fall_q;
        irq_d  = |flag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign edge_flag = flag_q;
    assign irq       = irq_q;
`else
    logic flag_clr_unused;

    assign flag_clr_unused = ^flag_clr;
    assign edge_flag       = '0;
    assign irq             = 1'b0;
`endif

endmodule

// File: tb/tb_di_debounce_array.sv
// Directed self-checking bench for di_debounce_array (CH=8, CW=8, INIT=0).
// Expectations for the flag/irq outputs follow whether DI_EDGE_IRQ_EN is defined.
module tb_di_debounce_array;

`ifdef DI_EDGE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] in_i;
    logic [7:0] shake_th;
    logic [7:0] di_o;
    logic [7:0] rise_p;
    logic [7:0] fall_p;
    logic [7:0] edge_flag;
    logic       irq;
    logic [7:0] flag_clr;

    int checks;
    int errors;

    di_debounce_array #(.CH(8), .CW(8), .INIT(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_i      (in_i),
        .shake_th  (shake_th),
        .di_o      (di_o),
        .rise_p    (rise_p),
        .fall_p    (fall_p),
        .edge_flag (edge_flag),
        .irq       (irq),
        .flag_clr  (flag_clr)
    );

    // 10 MHz clock
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_i     = 8'h00;
        shake_th = 8'd4;
        flag_clr = 8'h00;
        #20;
        checks++;
        if (di_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_di got %h want 00", di_o); end
        checks++;
        if (rise_p !== 8'h00 || fall_p !== 8'h00) begin
            errors++; $display("[TB] FAIL reset_pulse got rise %h fall %h want 00 00", rise_p, fall_p);
        end
        checks++;
        if (edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_flag got flag %h irq %b want 00 0", edge_flag, irq);
        end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (di_o !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_di got %h want 00", di_o); end
    endtask

    // Clean rise on channel 0 with threshold 4: update on the 6th edge after the change.
    task automatic test_rise_latency();
        logic [7:0] expDi;
        logic [7:0] expRise;
        in_i[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick(1);
            expDi   = (n >= 6) ? 8'h01 : 8'h00;
            expRise = (n == 6) ? 8'h01 : 8'h00;
            checks++;
            if (di_o !== expDi) begin errors++; $display("[TB] FAIL rise_di edge %0d got %h want %h", n, di_o, expDi); end
            checks++;
            if (rise_p !== expRise || fall_p !== 8'h00) begin
                errors++; $display("[TB] FAIL rise_pulse edge %0d got rise %h fall %h want %h 00", n, rise_p, fall_p, expRise);
            end
        end
    endtask

    task automatic test_clear_all();
        flag_clr = 8'hFF;
        tick(1);
        flag_clr = 8'h00;
        tick(2);
        checks++;
        if (edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_all got flag %h irq %b want 00 0", edge_flag, irq);
        end
    endtask

    // Three-cycle glitch on channel 3 stays under the threshold of 4.
    task automatic test_glitch();
        in_i[3] = 1'b1;
        tick(3);
        in_i[3] = 1'b0;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (di_o !== 8'h01 || rise_p !== 8'h00 || fall_p !== 8'h00 || edge_flag !== 8'h00 || irq !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch cyc %0d got di %h rise %h fall %h flag %h irq %b want 01 00 00 00 0",
                         n, di_o, rise_p, fall_p, edge_flag, irq);
            end
            tick(1);
        end
    endtask

    // Threshold 0 acts as 1: a one-cycle input pulse reappears on di_o three edges later.
    task automatic test_zero_threshold();
        logic expDi;
        logic expRise;
        logic expFall;
        shake_th = 8'd0;
        in_i[1]  = 1'b1;
        tick(1);
        in_i[1]  = 1'b0;
        for (int n = 2; n <= 6; n++) begin
            tick(1);
            expDi   = (n == 3);
            expRise = (n == 3);
            expFall = (n == 4);
            checks++;
            if (di_o !== {6'b0, expDi, 1'b1}) begin
                errors++; $display("[TB] FAIL zero_th_di edge %0d got %h want %h", n, di_o, {6'b0, expDi, 1'b1});
            end
            checks++;
            if (rise_p !== {6'b0, expRise, 1'b0} || fall_p !== {6'b0, expFall, 1'b0}) begin
                errors++; $display("[TB] FAIL zero_th_pulse edge %0d got rise %h fall %h want %b %b",
                                   n, rise_p, fall_p, expRise, expFall);
            end
        end
        shake_th = 8'd4;
    endtask

    // Channel 2 rises then falls; the clear strobe then lands on the cycle of a fresh rise.
    task automatic test_flag_set_wins();
        in_i[2] = 1'b1;
        tick(8);
        in_i[2] = 1'b0;
        tick(8);
        checks++;
        if (di_o !== 8'h01 || edge_flag[2] !== IRQ_EN) begin
            errors++; $display("[TB] FAIL fall_ch2 got di %h flag2 %b want 01 %b", di_o, edge_flag[2], IRQ_EN);
        end
        in_i[2] = 1'b1;
        tick(6);
        checks++;
        if (rise_p !== 8'h04) begin errors++; $display("[TB] FAIL rerise_ch2 got rise %h want 04", rise_p); end
        flag_clr = 8'h04;
        tick(1);
        flag_clr = 8'h00;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (edge_flag[2] !== IRQ_EN || irq !== IRQ_EN) begin
                errors++; $display("[TB] FAIL set_wins cyc %0d got flag2 %b irq %b want %b %b",
                                   n, edge_flag[2], irq, IRQ_EN, IRQ_EN);
            end
            tick(1);
        end
    endtask

    task automatic test_flag_clear();
        flag_clr = 8'h04;
        tick(1);
        flag_clr = 8'h00;
        checks++;
        if (edge_flag !== 8'h00 || irq !== IRQ_EN) begin
            errors++; $display("[TB] FAIL flag_clear got flag %h irq %b want 00 %b", edge_flag, irq, IRQ_EN);
        end
        tick(1);
        checks++;
        if (edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL irq_drop got flag %h irq %b want 00 0", edge_flag, irq);
        end
    endtask

    // Reset lands at count 50 of a 100-cycle threshold; the full count restarts after release.
    task automatic test_reset_mid_count();
        logic [7:0] expDi;
        logic [7:0] expRise;
        shake_th = 8'd100;
        in_i     = 8'hFF;
        rst_n    = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(52);
        checks++;
        if (di_o !== 8'h00) begin errors++; $display("[TB] FAIL count50_di got %h want 00", di_o); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (di_o !== 8'h00 || rise_p !== 8'h00) begin
            errors++; $display("[TB] FAIL in_reset_di got di %h rise %h want 00 00", di_o, rise_p);
        end
        tick(3);
        checks++;
        if (di_o !== 8'h00 || rise_p !== 8'h00 || fall_p !== 8'h00) begin
            errors++; $display("[TB] FAIL hold_reset got di %h rise %h fall %h want 00 00 00", di_o, rise_p, fall_p);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= 104; n++) begin
            tick(1);
            expDi   = (n >= 102) ? 8'hFF : 8'h00;
            expRise = (n == 102) ? 8'hFF : 8'h00;
            checks++;
            if (di_o !== expDi || rise_p !== expRise || fall_p !== 8'h00) begin
                errors++; $display("[TB] FAIL release edge %0d got di %h rise %h fall %h want %h %h 00",
                                   n, di_o, rise_p, fall_p, expDi, expRise);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rise_latency();
        test_clear_all();
        test_glitch();
        test_zero_threshold();
        test_clear_all();
        test_flag_set_wins();
        test_flag_clear();
        test_reset_mid_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
